// File: rtl/nios_mulx_sequencer_if.sv
// Request/response bus between a requester and the 32x32 multiply sequencer.
interface nios_mulx_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_a_signed;
    logic        req_b_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;

    // Requester side
    modport master (
        output req_valid, req_a, req_b, req_a_signed, req_b_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_a, req_b, req_a_signed, req_b_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/nios_mulx_sequencer.sv
// 32x32 -> 64 multiply built from one registered 16x16 unsigned multiplier.
// Partial products LL, LH, HL, HH are issued one per cycle, accumulated one
// cycle later, then a fix-up step applies two's complement sign corrections.
// Optional feature macro: MULX_SEQ_EARLY_OUT_EN -- operands whose upper
// halves are both zero finish after the LL product only.
module nios_mulx_sequencer (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_mulx_sequencer_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_a_signed;
    logic                r_b_signed;
    logic                r_early;
    logic [IDX_W-1:0]    r_issue_idx;
    logic [PROD_W-1:0]   r_prod;
    logic                r_prod_vld;
    logic [IDX_W-1:0]    r_prod_idx;
    logic [ACC_W-1:0]    r_acc;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [ACC_W-1:0]    r_rsp_result;

    logic                w_accept;
    logic                w_issue;
    logic                w_load_result;
    logic                w_use_fix;
    logic                w_early;
    logic [HALF_W-1:0]   w_mul_a;
    logic [HALF_W-1:0]   w_mul_b;
    logic [PROD_W-1:0]   w_mul_p;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [ACC_W-1:0]    w_corr_a;
    logic [ACC_W-1:0]    w_corr_b;
    logic [ACC_W-1:0]    w_fixed;

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;

`ifdef MULX_SEQ_EARLY_OUT_EN
    // Short path when both operands fit in 16 bits (no sign correction possible)
    assign w_early = (bus.req_a[DATA_W-1:HALF_W] == '0) &&
                     (bus.req_b[DATA_W-1:HALF_W] == '0);
`else
    assign w_early = 1'b0;
`endif

    // Operand half select: idx[1] picks the A half, idx[0] the B half (LL, LH, HL, HH)
    assign w_mul_a = r_issue_idx[1] ? r_a[DATA_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_mul_b = r_issue_idx[0] ? r_b[DATA_W-1:HALF_W] : r_b[HALF_W-1:0];
    assign w_mul_p = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);

    // Align the registered partial product by its position in the issue order
    always_comb begin
        w_addend = '0;
        case (r_prod_idx)
            2'd0:    w_addend = ACC_W'(r_prod);
            2'd1,
            2'd2:    w_addend = ACC_W'(r_prod) << HALF_W;
            default: w_addend = ACC_W'(r_prod) << DATA_W;
        endcase
    end

    assign w_acc_sum = r_acc + (r_prod_vld ? w_addend : '0);

    // Two's complement correction: a negative operand contributes -(other << 32)
    assign w_corr_a = (r_a_signed && r_a[DATA_W-1]) ? {r_b, 32'h0} : '0;
    assign w_corr_b = (r_b_signed && r_b[DATA_W-1]) ? {r_a, 32'h0} : '0;
    assign w_fixed  = r_acc - w_corr_a - w_corr_b;

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_issue       = 1'b0;
        w_load_result = 1'b0;
        w_use_fix     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (r_early || (r_issue_idx == 2'd3)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_early) begin
                    w_load_result = 1'b1;
                    w_state_next  = S_DONE;
                end else begin
                    w_state_next  = S_FIX;
                end
            end
            S_FIX: begin
                w_load_result = 1'b1;
                w_use_fix     = 1'b1;
                w_state_next  = S_DONE;
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs follow the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_req_ready <= (w_state_next == S_IDLE);
            r_rsp_valid <= (w_state_next == S_DONE);
        end
    end

    // Operand capture and issue sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_a_signed  <= 1'b0;
            r_b_signed  <= 1'b0;
            r_early     <= 1'b0;
            r_issue_idx <= '0;
        end else if (w_accept) begin
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_a_signed  <= bus.req_a_signed;
            r_b_signed  <= bus.req_b_signed;
            r_early     <= w_early;
            r_issue_idx <= '0;
        end else if (w_issue) begin
            r_issue_idx <= r_issue_idx + 2'd1;
        end
    end

    // Multiplier output register, tagged with which partial product it holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_prod_idx <= '0;
        end else begin
            r_prod_vld <= w_issue;
            if (w_issue) begin
                r_prod     <= w_mul_p;
                r_prod_idx <= r_issue_idx;
            end
        end
    end

    // Accumulator: cleared on acceptance, absorbs each product a cycle after issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_prod_vld) begin
            r_acc <= w_acc_sum;
        end
    end

    // Result register holds the last completed product between operations
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_result <= '0;
        end else if (w_load_result) begin
            r_rsp_result <= w_use_fix ? w_fixed : w_acc_sum;
        end
    end

endmodule

// File: tb/tb_nios_mulx_sequencer.sv
// Directed bench for nios_mulx_sequencer; latency expectations track MULX_SEQ_EARLY_OUT_EN.
module tb_nios_mulx_sequencer;
    localparam int LAT_FULL = 6;
`ifdef MULX_SEQ_EARLY_OUT_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = 6;
`endif
    localparam int WAIT_MAX = 40;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    nios_mulx_sequencer_if bus ();

    nios_mulx_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present a request and return just after the accepting edge
    task automatic start_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic as, input logic bs);
        int w;
        w = 0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_a_signed = as;
        bus.req_b_signed = bs;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_accept_wait"}, 64'(w < 20), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_a        = 32'hDEAD_BEEF;
        bus.req_b        = 32'h0BAD_F00D;
        bus.req_a_signed = ~as;
        bus.req_b_signed = ~bs;
        chk({tag, "_ready_low_busy"}, 64'(bus.req_ready), 64'd0);
    endtask

    // Count edges after acceptance until rsp_valid is seen
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < WAIT_MAX) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic as, input logic bs, input logic [63:0] exp,
                           input int exp_lat);
        int n;
        start_req(tag, a, b, as, bs);
        wait_rsp(n);
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_result"}, bus.rsp_result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_result_hold"}, bus.rsp_result, exp);
    endtask

    initial begin
        int  n;
        logic [63:0] held;
        logic saw_valid;
        errors           = 0;
        checks           = 0;
        reset_n          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_a_signed = 1'b0;
        bus.req_b_signed = 1'b0;
        bus.rsp_ready    = 1'b1;

        #3;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(bus.req_ready), 64'd1);
        chk("result_after_reset", bus.rsp_result, 64'd0);

        run_vec("uu_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, LAT_FULL);
        run_vec("ss_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, LAT_FULL);
        run_vec("s_neg2_x3",  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, LAT_FULL);
        run_vec("small",      32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 64'h0000_0000_0626_0060, LAT_SHORT);
        run_vec("ss_min",     32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, LAT_FULL);
        run_vec("hh_only",    32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, LAT_FULL);
        run_vec("ll_max",     32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b1, 64'h0000_0000_FFFE_0001, LAT_SHORT);
        run_vec("s5_xneg1",   32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, LAT_FULL);
        run_vec("su_mixed",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, LAT_FULL);

        // Back-pressure: result held stable while the consumer stalls
        bus.rsp_ready = 1'b0;
        start_req("stall", 32'h0003_0000, 32'h0000_0005, 1'b0, 1'b0);
        wait_rsp(n);
        chk("stall_latency", 64'(n), 64'(LAT_FULL));
        chk("stall_result", bus.rsp_result, 64'h0000_0000_000F_0000);
        held = bus.rsp_result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_hold_%0d", i), bus.rsp_result, 64'h0000_0000_000F_0000);
            chk($sformatf("stall_valid_%0d", i), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("stall_ready_%0d", i), 64'(bus.req_ready), 64'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_valid_drop", 64'(bus.rsp_valid), 64'd0);
        chk("stall_idle_ready", 64'(bus.req_ready), 64'd1);
        chk("stall_result_kept", bus.rsp_result, held);

        // Reset in the middle of an operation discards it
        start_req("abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_rsp_result", bus.rsp_result, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        chk("abort_no_rsp", 64'(saw_valid), 64'd0);
        chk("abort_result_zero", bus.rsp_result, 64'd0);
        run_vec("after_abort", 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 64'd6, LAT_SHORT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nios_mulx_sequencer.md
NIOS_MULX_SEQUENCER -- requirements
Module: nios_mulx_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_valid  input  1  request present.
REQ-004 SHALL have port: req_ready  output  1  sequencer can accept a request.
REQ-005 SHALL have port: req_a  input  32  operand A.
REQ-006 SHALL have port: req_b  input  32  operand B.
REQ-007 SHALL have port: req_a_signed  input  1  treat A as two's complement.
REQ-008 SHALL have port: req_b_signed  input  1  treat B as two's complement.
REQ-009 SHALL have port: rsp_valid  output  1  result present.
REQ-010 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-011 SHALL have port: rsp_result  output  64  full product A*B.

Function
REQ-012 SHALL contain one internal 16x16 unsigned multiplier with a 32-bit output register and 1-cycle latency, and SHALL use no other multiplier.
REQ-013 SHALL implement the FSM states IDLE, ISSUE, DRAIN, FIX and DONE.
REQ-014 SHALL assert req_ready only in IDLE; acceptance is req_valid && req_ready at edge T.
REQ-015 SHALL latch req_a, req_b and both sign flags at acceptance, and SHALL ignore later input changes until the next acceptance.
REQ-016 SHALL spend cycles T+1..T+4 in ISSUE, driving the partial products in fixed order LL, LH, HL, HH (L = bits 15:0, H = bits 31:16, first letter = A).
REQ-017 SHALL clear the 64-bit accumulator at acceptance.
REQ-018 SHALL add each registered product to the accumulator one cycle after it is issued, shifted left by 0, 16, 16 and 32 bits respectively, with arithmetic modulo 2^64.
REQ-019 SHALL spend cycle T+5 in DRAIN, absorbing the HH product.
REQ-020 SHALL spend cycle T+6 in FIX, where: if req_a_signed and A[31], subtract B<<32; if req_b_signed and B[31], subtract A<<32; both subtractions modulo 2^64 in the same cycle.
REQ-021 SHALL assert rsp_valid from T+7 in DONE, holding rsp_result stable while rsp_valid && !rsp_ready.
REQ-022 SHALL return to IDLE on the edge where rsp_valid && rsp_ready, dropping rsp_valid; req_ready rises the following cycle, so the minimum request spacing is 8 cycles.
REQ-023 SHALL keep rsp_result equal to the last completed product outside DONE, and 0 after reset.
REQ-024 SHALL ignore req_valid in every state other than IDLE (no queueing).

Reset
REQ-025 SHALL, while reset_n is low, force state IDLE, req_ready=0, rsp_valid=0, rsp_result=0, accumulator=0 and product register=0 immediately (asynchronously).
REQ-026 SHALL drive req_ready=1 in the first cycle after reset_n deasserts.
REQ-027 SHALL discard any operation in flight when reset asserts, producing no response for it.

Configuration
REQ-028 SHALL honour the macro MULX_SEQ_EARLY_OUT_EN.
REQ-029 With MULX_SEQ_EARLY_OUT_EN defined, when A[31:16]==0 and B[31:16]==0 at acceptance, SHALL issue only LL (T+1), DRAIN at T+2, skip FIX and assert rsp_valid from T+3; all other operands take the full path.
REQ-030 Without MULX_SEQ_EARLY_OUT_EN, SHALL give every operation the 7-cycle latency, with no operand-dependent timing.

Verification
REQ-031 Bench SHALL check: A=B=0xFFFFFFFF, unsigned -> rsp_result=0xFFFFFFFE00000001, rsp_valid at T+7.
REQ-032 Bench SHALL check: A=B=0xFFFFFFFF, both signed -> rsp_result=0x0000000000000001.
REQ-033 Bench SHALL check: A=0xFFFFFFFE signed, B=3 unsigned -> rsp_result=0xFFFFFFFFFFFFFFFA.
REQ-034 Bench SHALL check: A=0x1234, B=0x5678 -> rsp_result=0x0000000006260060, at T+3 with the macro and T+7 without.
REQ-035 Bench SHALL check: rsp_ready held low 5 cycles after rsp_valid -> result stable and req_ready=0 throughout, IDLE one cycle after the handshake.
REQ-036 Bench SHALL check: reset_n pulsed low at T+3 -> rsp_valid never rises, all outputs 0, and the next request (A=2, B=3) returns 6.
